// File: rtl/riscv_hazard_scoreboard.sv
// riscv_hazard_scoreboard: hazards that forwarding cannot cover (load-use, long-op RAW/WAW, long-op limit, branch squash).
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_events counters.
module riscv_hazard_scoreboard #(
    parameter int MAX_LONG = 4,
    parameter int CNT_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    rs1_d,
    input  logic [4:0]                    rs2_d,
    input  logic                          rs1_used_d,
    input  logic                          rs2_used_d,
    input  logic [4:0]                    rd_d,
    input  logic                          long_op_d,
    input  logic                          valid_e,
    input  logic [4:0]                    rd_e,
    input  logic                          reg_write_e,
    input  logic                          mem_read_e,
    input  logic                          long_op_e,
    input  logic                          long_done,
    input  logic [4:0]                    long_rd,
    input  logic                          branch_taken_e,
    output logic                          stall_f,
    output logic                          stall_d,
    output logic                          flush_d,
    output logic                          flush_e,
    output logic [31:0]                   busy_mask,
    output logic [$clog2(MAX_LONG+1)-1:0] long_count,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              flush_events,
`endif
    output logic                          sb_error
);
    localparam int LCW = $clog2(MAX_LONG + 1);
    localparam logic [LCW-1:0] FULL = LCW'(MAX_LONG);
    localparam logic [LCW-1:0] NEAR = LCW'(MAX_LONG - 1);

    if (MAX_LONG < 1 || MAX_LONG > 15 || CNT_W < 1) begin : g_param_check
        $error("riscv_hazard_scoreboard: MAX_LONG must be 1..15 and CNT_W >= 1");
    end

    logic [31:0]    busy_q, busy_d;
    logic [LCW-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           dispatch, cnt_full, load_use, raw_sb, struct_haz, hazard;
    logic           done_bad, done_ok;

    // hazard detection and pipeline controls; a taken branch overrides any stall
    always_comb begin
        dispatch   = valid_e & long_op_e;
        cnt_full   = cnt_q == FULL;
        load_use   = valid_e & mem_read_e & reg_write_e & (rd_e != 5'd0)
                   & ((rs1_used_d & (rs1_d == rd_e)) | (rs2_used_d & (rs2_d == rd_e)));
        raw_sb     = (rs1_used_d & busy_q[rs1_d]) | (rs2_used_d & busy_q[rs2_d]);
        struct_haz = long_op_d & (((rd_d != 5'd0) & busy_q[rd_d]) | cnt_full | (dispatch & (cnt_q == NEAR)));
        hazard     = load_use | raw_sb | struct_haz;
        stall_f    = ~rst & hazard & ~branch_taken_e;
        stall_d    = ~rst & hazard & ~branch_taken_e;
        flush_d    = ~rst & branch_taken_e;
        flush_e    = ~rst & (hazard | branch_taken_e);
    end

    // scoreboard next state; illegal completions are ignored but flagged, set beats clear
    always_comb begin
        done_bad = long_done & ((cnt_q == '0) | ((long_rd != 5'd0) & ~busy_q[long_rd]));
        done_ok  = long_done & ~done_bad;
        busy_d   = busy_q & ~(done_ok ? 32'd1 << long_rd : 32'd0);
        busy_d   = busy_d | ((dispatch & (rd_e != 5'd0)) ? 32'd1 << rd_e : 32'd0);
        cnt_d    = cnt_q + LCW'(dispatch & ~cnt_full) - LCW'(done_ok);
        err_d    = err_q | done_bad | (dispatch & cnt_full);
    end

    // scoreboard state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_mask  = busy_q;
    assign long_count = cnt_q;
    assign sb_error   = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_d & ~&stall_cnt_q);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_d & ~&flush_cnt_q);
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif
endmodule

// File: doc/riscv_hazard_scoreboard.md
Name: riscv_hazard_scoreboard

Overview:
Producer-side hazard control for the 5-stage core. It pairs with the EX-stage forwarding logic and covers every hazard that forwarding cannot resolve:
- load-use hazards
- pending writes from multi-cycle mul/div ops, tracked by a register scoreboard
- WAW conflicts and structural limits on outstanding long ops
- taken-branch squash

It sits alongside decode and drives the stall and flush controls of the IF/ID and ID/EX pipeline registers.

Parameters:
MAX_LONG, 4, maximum outstanding long-latency ops (1..15)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
rs1_d  input  5  decode rs1 index
rs2_d  input  5  decode rs2 index
rs1_used_d  input  1  decode instruction reads rs1
rs2_used_d  input  1  decode instruction reads rs2
rd_d  input  5  decode destination index
long_op_d  input  1  decode instruction is a long op (mul/div)
valid_e  input  1  EX holds a valid instruction
rd_e  input  5  EX destination index
reg_write_e  input  1  EX instruction writes rd
mem_read_e  input  1  EX instruction is a load
long_op_e  input  1  EX instruction is a long op; dispatches at end of this cycle
long_done  input  1  long-op unit writes back this cycle
long_rd  input  5  destination of completing long op
branch_taken_e  input  1  taken branch/jump resolved in EX
stall_f  output  1  hold PC
stall_d  output  1  hold IF/ID
flush_d  output  1  clear IF/ID
flush_e  output  1  insert bubble into ID/EX
busy_mask  output  32  scoreboard pending-write bits; bit 0 always 0
long_count  output  $clog2(MAX_LONG+1)  outstanding long ops
sb_error  output  1  sticky protocol-violation flag

Behaviour:
Hazard terms (combinational, same cycle):
- load_use = valid_e & mem_read_e & reg_write_e & rd_e!=0 & ((rs1_used_d & rs1_d==rd_e) | (rs2_used_d & rs2_d==rd_e)).
- raw_sb = (rs1_used_d & busy[rs1_d]) | (rs2_used_d & busy[rs2_d]).
- A completion in the same cycle (long_done, long_rd) does NOT clear raw_sb. There is no bypass; the clear is visible next cycle.
- dispatch = valid_e & long_op_e.
- struct = long_op_d & ((rd_d!=0 & busy[rd_d]) | long_count==MAX_LONG | (dispatch & long_count==MAX_LONG-1)).
- hazard = load_use | raw_sb | struct.

Output equations:
- stall_f = stall_d = hazard & ~branch_taken_e. Wrong-path decode is never stalled.
- flush_d = branch_taken_e.
- flush_e = hazard | branch_taken_e.
- While rst=1, all four controls are 0.

Sequential updates (registered, visible next cycle):
- Dispatch with rd_e!=0 sets busy[rd_e].
- long_done clears busy[long_rd].
- Same register set and cleared in one cycle: set wins.
- long_count: +1 on dispatch, -1 on long_done; both in the same cycle → unchanged.

sb_error is set and held until reset on any of:
- long_done while long_count==0 or busy[long_rd]==0 (for long_rd!=0). No decrement and no clear in that cycle.
- dispatch while long_count==MAX_LONG. Count saturates; busy bit is still set.

Reset (synchronous):
- busy_mask=0, long_count=0, sb_error=0.
- A reset asserted mid-operation discards all pending entries. Any long_done arriving after reset sets sb_error, so the long-op unit must be reset together with this block.

Register x0 is never busy and never hazards.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds output ports stall_cycles [CNT_W] and flush_events [CNT_W].
  - stall_cycles increments on every cycle with stall_d=1.
  - flush_events increments on every cycle with flush_d=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Load-use: EX lw x5 (valid_e=1, mem_read_e=1, reg_write_e=1, rd_e=5); decode reads rs1_d=5 → stall_f=stall_d=flush_e=1 for exactly 1 cycle. With rd_e=0 → no stall.
- Scoreboard RAW: dispatch div rd_e=7 → busy_mask[7]=1 and long_count=1 next cycle. Decode rs2_d=7 stalls until the cycle after long_done with long_rd=7. In the completion cycle itself, stall is still 1.
- Structural/WAW:
  - MAX_LONG=4 with 4 outstanding ops and long_op_d=1 → stall.
  - Same cycle as dispatch + long_done → long_count unchanged.
  - long_op_d with rd_d busy → stall.
- Branch priority: load_use=1 and branch_taken_e=1 together → flush_d=1, flush_e=1, stall_f=stall_d=0.
- Error/reset:
  - long_done with long_count=0 → sb_error=1, held until reset.
  - rst=1 for 1 cycle with 3 ops outstanding → busy_mask=0, long_count=0, sb_error=0, all controls 0 during reset.
- HAZARD_PERF_CNT_EN: 3 stall cycles and 2 branches → stall_cycles=3, flush_events=2. Preload near all-ones → saturates.
